// File: rtl/idm_access_ctrl_pkg.sv
// Shared definitions for the IDM access controller: widths, memory depth,
// the END instruction encoding and the controller state encoding.
package idm_pkg;

  localparam int IDM_AW    = 16;
  localparam int IDM_DW    = 16;
  localparam int IDM_DEPTH = 64;

  localparam logic [IDM_DW-1:0] END_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } idm_state_e;

  // True when the address maps onto an implemented memory word.
  function automatic logic addr_in_range(input logic [IDM_AW-1:0] a);
    return a < IDM_AW'(IDM_DEPTH);
  endfunction

endpackage

// File: rtl/idm_access_ctrl_if.sv
// Bus bundle between the datapath/memory side (master) and the IDM access
// controller (slave). addr_err exists only when IDM_ACCESS_BOUNDS_CHK_EN is defined.
interface idm_access_ctrl_if;
  import idm_pkg::*;

  // requester side
  logic              if_req;
  logic [IDM_AW-1:0] if_addr;
  logic              d_req;
  logic              d_we;
  logic [IDM_AW-1:0] d_addr;
  logic [IDM_DW-1:0] d_wdata;
  logic [IDM_DW-1:0] ir;
  logic [IDM_DW-1:0] mdr;
  logic              if_done;
  logic              d_done;
  logic              busy;
  logic              halted;
  // memory port
  logic [IDM_AW-1:0] mem_a;
  logic [IDM_DW-1:0] mem_wd;
  logic              mem_we;
  logic [IDM_DW-1:0] mem_rd;
`ifdef IDM_ACCESS_BOUNDS_CHK_EN
  logic              addr_err;
`endif

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output ir, mdr, if_done, d_done, busy, halted, mem_a, mem_wd, mem_we
`ifdef IDM_ACCESS_BOUNDS_CHK_EN
    , output addr_err
`endif
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  ir, mdr, if_done, d_done, busy, halted, mem_a, mem_wd, mem_we
`ifdef IDM_ACCESS_BOUNDS_CHK_EN
    , input addr_err
`endif
  );

endinterface

// File: rtl/idm_access_ctrl.sv
// Multi-cycle initiator for the unified 64x16 instruction/data memory.
// Serialises fetch and load/store requests onto one memory port, one access
// per three cycles, with data requests taking priority over fetches.
// Optional: define IDM_ACCESS_BOUNDS_CHK_EN to add out-of-range detection
// (addr_err), write suppression and zeroed read results for bad addresses.
module idm_access_ctrl
  import idm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  idm_access_ctrl_if.slave   bus
);

  idm_state_e        state_q;
  logic [IDM_DW-1:0] ir_q;
  logic [IDM_DW-1:0] mdr_q;
  logic [IDM_AW-1:0] mem_a_q;
  logic [IDM_DW-1:0] mem_wd_q;
  logic              mem_we_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              busy_q;
  logic              halted_q;
  logic              err_q;      // accepted address was out of range

  // Address that will be accepted this cycle if a request is taken in IDLE.
  logic [IDM_AW-1:0] sel_addr_d;
  logic              sel_err_d;

  assign sel_addr_d = bus.d_req ? bus.d_addr : bus.if_addr;

`ifdef IDM_ACCESS_BOUNDS_CHK_EN
  assign sel_err_d = !addr_in_range(sel_addr_d);
`else
  assign sel_err_d = 1'b0;
`endif

  // Access sequencer: accept in IDLE, one access cycle, one done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      mdr_q     <= '0;
      mem_a_q   <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.d_req) begin
            state_q  <= bus.d_we ? S_STORE : S_LOAD;
            mem_a_q  <= sel_addr_d;
            mem_wd_q <= bus.d_wdata;
            mem_we_q <= bus.d_we & ~sel_err_d;
            err_q    <= sel_err_d;
            busy_q   <= 1'b1;
          end else if (bus.if_req && !halted_q) begin
            state_q <= S_FETCH;
            mem_a_q <= sel_addr_d;
            err_q   <= sel_err_d;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q <= err_q ? '0 : bus.mem_rd;
          if (!err_q && bus.mem_rd == END_WORD) halted_q <= 1'b1;
          if_done_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_LOAD: begin
          mdr_q    <= err_q ? '0 : bus.mem_rd;
          d_done_q <= 1'b1;
          state_q  <= S_DONE;
        end
        S_STORE: begin
          mem_we_q <= 1'b0;
          d_done_q <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ir      = ir_q;
  assign bus.mdr     = mdr_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_wd  = mem_wd_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.if_done = if_done_q;
  assign bus.d_done  = d_done_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;

`ifdef IDM_ACCESS_BOUNDS_CHK_EN
  // Error flag is shown only during the done pulse of the offending access.
  assign bus.addr_err = err_q & (if_done_q | d_done_q);
`endif

endmodule

// File: tb/tb_idm_access_ctrl.sv
// Self-checking bench for idm_access_ctrl with a behavioural 64x16 memory.
// Define IDM_ACCESS_BOUNDS_CHK_EN to also exercise the bounds-check feature.
module tb_idm_access_ctrl;

  logic clk;
  logic rst_n;
  idm_access_ctrl_if bus ();

  idm_access_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  logic [15:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_a[5:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[5:0]] <= bus.mem_wd;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          done_cyc;   // negedge index of first matching done, -1 if none
    int          done_cnt;
    int          other_cnt;  // done pulses of the wrong type
    int          we_cnt;
    int          busy_cnt;
    int          err_cnt;
    logic [15:0] a_we;
    logic [15:0] wd_we;
  } res_t;

  // One access: drive after a negedge, observe n negedges, drop req at done.
  task automatic run_access(input bit fetch, input bit we, input logic [15:0] addr,
                            input logic [15:0] wd, input int n, output res_t r);
    r = '{-1, 0, 0, 0, 0, 0, 16'h0, 16'h0};
    @(negedge clk);
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin r.we_cnt++; r.a_we = bus.mem_a; r.wd_we = bus.mem_wd; end
      if (bus.busy) r.busy_cnt++;
`ifdef IDM_ACCESS_BOUNDS_CHK_EN
      if (bus.addr_err) r.err_cnt++;
`endif
      if ((fetch && bus.if_done) || (!fetch && bus.d_done)) begin
        r.done_cnt++;
        if (r.done_cyc < 0) r.done_cyc = i;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
      end
      if ((fetch && bus.d_done) || (!fetch && bus.if_done)) r.other_cnt++;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          fetch;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp_data;   // ir for fetch, mdr for load, ignored for store
  } vec_t;

  vec_t vecs [7];
  res_t r;
  int   d_at, f_at;

  initial begin
    vecs[0] = '{"fetch0",   1'b1, 1'b0, 16'd0,  16'h0000, 16'hC0F2};
    vecs[1] = '{"store44",  1'b0, 1'b1, 16'd44, 16'h000F, 16'h0000};
    vecs[2] = '{"load44",   1'b0, 1'b0, 16'd44, 16'h0000, 16'h000F};
    vecs[3] = '{"load45",   1'b0, 1'b0, 16'd45, 16'h0000, 16'h00FF};
    vecs[4] = '{"store10",  1'b0, 1'b1, 16'd10, 16'h1234, 16'h0000};
    vecs[5] = '{"fetch10",  1'b1, 1'b0, 16'd10, 16'h0000, 16'h1234};
    vecs[6] = '{"load39",   1'b0, 1'b0, 16'd39, 16'h0000, 16'h0001};

    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'hC0F2; mem[8] = 16'hFFFF; mem[39] = 16'h0001;
    mem[45] = 16'h00FF; mem[46] = 16'h0055;

    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ir", bus.ir, 16'h0);
    check("rst_mdr", bus.mdr, 16'h0);
    check("rst_mem_a", bus.mem_a, 16'h0);
    check("rst_flags", {11'd0, bus.mem_we, bus.if_done, bus.d_done, bus.busy, bus.halted}, 16'h0);
    rst_n = 1'b1;

    // Table-driven single accesses.
    foreach (vecs[i]) begin
      run_access(vecs[i].fetch, vecs[i].we, vecs[i].addr, vecs[i].wd, 4, r);
      check({vecs[i].name, "_done_cyc"}, 16'(r.done_cyc), 16'd2);
      check({vecs[i].name, "_done_cnt"}, 16'(r.done_cnt), 16'd1);
      check({vecs[i].name, "_other_done"}, 16'(r.other_cnt), 16'd0);
      check({vecs[i].name, "_busy_cycles"}, 16'(r.busy_cnt), 16'd2);
      check({vecs[i].name, "_we_cycles"}, 16'(r.we_cnt), vecs[i].we ? 16'd1 : 16'd0);
      check({vecs[i].name, "_err"}, 16'(r.err_cnt), 16'd0);
      if (vecs[i].we) begin
        check({vecs[i].name, "_mem_a"}, r.a_we, vecs[i].addr);
        check({vecs[i].name, "_mem_wd"}, r.wd_we, vecs[i].wd);
      end else if (vecs[i].fetch) begin
        check({vecs[i].name, "_ir"}, bus.ir, vecs[i].exp_data);
      end else begin
        check({vecs[i].name, "_mdr"}, bus.mdr, vecs[i].exp_data);
      end
      $display("vec %s addr=%0d ir=%h mdr=%h done_cyc=%0d", vecs[i].name, vecs[i].addr,
               bus.ir, bus.mdr, r.done_cyc);
    end

    // Simultaneous fetch (addr 0) and load (addr 45): load first, fetch 3 cycles later.
    d_at = -1; f_at = -1;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 16'd0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd45;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.d_done && d_at < 0) begin
        d_at = i; bus.d_req = 1'b0;
        check("both_mdr", bus.mdr, 16'h00FF);
      end
      if (bus.if_done && f_at < 0) begin f_at = i; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    check("both_d_done_cyc", 16'(d_at), 16'd2);
    check("both_if_done_cyc", 16'(f_at), 16'd5);
    check("both_ir", bus.ir, 16'hC0F2);
    $display("both: d_done@%0d if_done@%0d mdr=%h ir=%h", d_at, f_at, bus.mdr, bus.ir);

    // Fetch the END word -> halted.
    run_access(1'b1, 1'b0, 16'd8, 16'h0, 4, r);
    check("halt_ir", bus.ir, 16'hFFFF);
    check("halt_flag", {15'd0, bus.halted}, 16'd1);
    $display("fetch8: ir=%h halted=%b", bus.ir, bus.halted);

    // Fetch while halted: never serviced.
    run_access(1'b1, 1'b0, 16'd0, 16'h0, 8, r);
    check("halted_no_if_done", 16'(r.done_cnt), 16'd0);
    check("halted_not_busy", 16'(r.busy_cnt), 16'd0);
    check("halted_ir_kept", bus.ir, 16'hFFFF);
    $display("fetch0 while halted: done_cnt=%0d busy_cnt=%0d", r.done_cnt, r.busy_cnt);

    // Loads still work while halted.
    run_access(1'b0, 1'b0, 16'd39, 16'h0, 4, r);
    check("halted_load_done", 16'(r.done_cyc), 16'd2);
    check("halted_load_mdr", bus.mdr, 16'h0001);
    check("halted_still", {15'd0, bus.halted}, 16'd1);
    $display("load39 while halted: mdr=%h", bus.mdr);

    // Reset during a store to 46: write must not happen.
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd46; bus.d_wdata = 16'h00AA;
    @(posedge clk);
    #2;
    check("rst_store_we_before", {15'd0, bus.mem_we}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("rst_store_we_drop", {15'd0, bus.mem_we}, 16'd0);
    check("rst_store_flags", {11'd0, bus.mem_we, bus.if_done, bus.d_done, bus.busy, bus.halted}, 16'h0);
    check("rst_store_regs", bus.ir | bus.mdr | bus.mem_a | bus.mem_wd, 16'h0);
    bus.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_store_mem46", mem[46], 16'h0055);
    rst_n = 1'b1;
    $display("reset mid-store: mem[46]=%h halted=%b", mem[46], bus.halted);

    // After reset the halt is cleared; fetch is served again.
    run_access(1'b1, 1'b0, 16'd0, 16'h0, 4, r);
    check("post_rst_fetch_done", 16'(r.done_cyc), 16'd2);
    check("post_rst_fetch_ir", bus.ir, 16'hC0F2);
    $display("fetch0 after reset: ir=%h", bus.ir);

`ifdef IDM_ACCESS_BOUNDS_CHK_EN
    run_access(1'b0, 1'b1, 16'd64, 16'h1111, 4, r);
    check("oob_store_done", 16'(r.done_cyc), 16'd2);
    check("oob_store_we", 16'(r.we_cnt), 16'd0);
    check("oob_store_err", 16'(r.err_cnt), 16'd1);
    check("oob_store_mem0", mem[0], 16'hC0F2);
    $display("store64: we_cnt=%0d err_cnt=%0d", r.we_cnt, r.err_cnt);
    run_access(1'b0, 1'b0, 16'd70, 16'h0, 4, r);
    check("oob_load_done", 16'(r.done_cyc), 16'd2);
    check("oob_load_mdr", bus.mdr, 16'h0000);
    check("oob_load_err", 16'(r.err_cnt), 16'd1);
    $display("load70: mdr=%h err_cnt=%0d", bus.mdr, r.err_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the sequence above is bounded, this only catches a stuck simulator.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
